// File: rtl/io_responder_pkg.sv
// Shared CPU-bus definitions: I/O window base, register offsets and STATUS layout
// used by the responder, the memory and the top-level decode.
package io_responder_pkg;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFFF0;

    typedef enum logic [1:0] {
        REG_LED    = 2'd0,
        REG_SW     = 2'd1,
        REG_TIMER  = 2'd2,
        REG_STATUS = 2'd3
    } io_reg_e;

    localparam int STAT_TF  = 0;
    localparam int STAT_TIE = 1;
    localparam int STAT_SCF = 2;
    localparam int STAT_SIE = 3;

    // Field order matches the STAT_* bit positions (tf is bit 0).
    typedef struct packed {
        logic sie;
        logic scf;
        logic tie;
        logic tf;
    } status_t;

    function automatic logic [7:0] status_byte(status_t s);
        return {4'b0000, s};
    endfunction

endpackage

// File: rtl/io_responder_timer.sv
// Prescaled 8-bit reloading down counter; expire pulses on the edge the count reloads.
module io_timer #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       expire
);

    localparam logic [7:0] PSC_LAST = 8'(PRESCALE - 1);

    logic [7:0] reload;
    logic [7:0] psc;
    logic       tick;

    // A reload value of zero means stopped; a load always wins over a tick.
    assign tick   = (reload != 8'd0) && !load && (psc == PSC_LAST);
    assign expire = tick && (count <= 8'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload <= 8'd0;
            count  <= 8'd0;
            psc    <= 8'd0;
        end else if (load) begin
            reload <= load_val;
            count  <= load_val;
            psc    <= 8'd0;
        end else if (reload != 8'd0) begin
            if (tick) begin
                psc   <= 8'd0;
                count <= (count <= 8'd1) ? reload : count - 8'd1;
            end else begin
                psc <= psc + 8'd1;
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: LED, synchronized switches, timer and interrupt status
// in a 4-byte window, with a registered read path.
module io_responder
    import io_responder_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          PRESCALE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        read,
    input  logic        write,
    output logic [7:0]  data_out,
    output logic        io_sel,
    input  logic [7:0]  sw_in,
    output logic [7:0]  led_out,
    output logic        irq
);

    io_reg_e    reg_sel;
    logic       wr_en;
    logic       rd_en;
    logic       wr_led;
    logic       wr_timer;
    logic       wr_status;
    logic [7:0] sw_meta;
    logic [7:0] sw_sync;
    logic       scf_set;
    logic       tf_set;
    logic [7:0] timer_count;
    logic [7:0] rdata;
    status_t    status;

    assign io_sel    = (addr[15:2] == BASE_ADDR[15:2]) && (read || write);
    assign reg_sel   = io_reg_e'(addr[1:0]);
    assign wr_en     = io_sel && write;
    assign rd_en     = io_sel && read && !write;
    assign wr_led    = wr_en && (reg_sel == REG_LED);
    assign wr_timer  = wr_en && (reg_sel == REG_TIMER);
    assign wr_status = wr_en && (reg_sel == REG_STATUS);

    io_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_timer),
        .load_val (data_in),
        .count    (timer_count),
        .expire   (tf_set)
    );

    // sw_meta absorbs metastability; sw_sync is the architectural SW register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta <= 8'd0;
            sw_sync <= 8'd0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    assign scf_set = (sw_meta != sw_sync);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_out <= 8'd0;
        end else if (wr_led) begin
            led_out <= data_in;
        end
    end

    // Hardware set of TF/SCF overrides a simultaneous write-one-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status <= '0;
        end else begin
            status.tf  <= tf_set  | (status.tf  & ~(wr_status & data_in[STAT_TF]));
            status.scf <= scf_set | (status.scf & ~(wr_status & data_in[STAT_SCF]));
            if (wr_status) begin
                status.tie <= data_in[STAT_TIE];
                status.sie <= data_in[STAT_SIE];
            end
        end
    end

    // NOTE: rdata gets a default before the case so no latch is inferred.
    always_comb begin
        rdata = 8'd0;
        case (reg_sel)
            REG_LED:    rdata = led_out;
            REG_SW:     rdata = sw_sync;
            REG_TIMER:  rdata = timer_count;
            REG_STATUS: rdata = status_byte(status);
            default:    rdata = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out <= 8'd0;
        end else begin
            data_out <= rd_en ? rdata : 8'd0;
        end
    end

    assign irq = (status.tf & status.tie) | (status.scf & status.sie);

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: directed scenarios plus random bus traffic
// against a cycle-indexed arithmetic reference model.
module tb_io_responder;
    import io_responder_pkg::*;

    localparam logic [15:0] BASE = 16'hFFF0;
    localparam int          P    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        read;
    logic        write;
    logic [7:0]  data_out;
    logic        io_sel;
    logic [7:0]  sw_in;
    logic [7:0]  led_out;
    logic        irq;

    io_responder #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .read     (read),
        .write    (write),
        .data_out (data_out),
        .io_sel   (io_sel),
        .sw_in    (sw_in),
        .led_out  (led_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] dout;
        logic [7:0] led;
        logic       irq;
        logic       sel;
    } exp_t;

    exp_t sb[$];

    // Reference model: timer state kept as (reload, edge of last load) and evaluated arithmetically.
    int         cyc;
    logic [7:0] m_led, m_rl, m_sync, m_sample;
    int         m_load_e;
    logic       m_tf, m_tie, m_scf, m_sie;
    logic [7:0] sw_cur;

    function automatic logic [7:0] m_count(input int e);
        int el;
        if (m_rl == 8'd0) return 8'd0;
        el = e - m_load_e;
        return 8'(int'(m_rl) - ((el / P) % int'(m_rl)));
    endfunction

    function automatic bit m_expire(input int e);
        int el;
        if (m_rl == 8'd0) return 1'b0;
        el = e - m_load_e;
        return (el > 0) && (el % P == 0) && (((el / P) % int'(m_rl)) == 0);
    endfunction

    task automatic model_reset();
        cyc = 0; m_led = 0; m_rl = 0; m_load_e = 0; m_sync = 0; m_sample = 0;
        m_tf = 0; m_tie = 0; m_scf = 0; m_sie = 0;
    endtask

    task automatic model_edge(input logic [15:0] a, input logic [7:0] d,
                              input logic rd, input logic wr, input logic [7:0] sw);
        exp_t       x;
        int         e;
        bit         sel, wr_t, wr_s, tf_hw, scf_hw;
        logic [1:0] off;
        logic [7:0] rdata;
        e   = cyc + 1;
        sel = (a[15:2] == BASE[15:2]) && (rd || wr);
        off = a[1:0];
        case (off)
            2'd0:    rdata = m_led;
            2'd1:    rdata = m_sync;
            2'd2:    rdata = m_count(cyc);
            default: rdata = {4'b0, m_sie, m_scf, m_tie, m_tf};
        endcase
        x.dout = (sel && rd && !wr) ? rdata : 8'h00;
        wr_t   = sel && wr && (off == 2'd2);
        wr_s   = sel && wr && (off == 2'd3);
        tf_hw  = m_expire(e) && !wr_t;
        scf_hw = (m_sample != m_sync);
        m_sync   = m_sample;
        m_sample = sw;
        if (sel && wr && off == 2'd0) m_led = d;
        if (wr_t) begin m_rl = d; m_load_e = e; end
        if (wr_s) begin
            m_tf  = tf_hw  | (m_tf  & ~d[0]);
            m_scf = scf_hw | (m_scf & ~d[2]);
            m_tie = d[1];
            m_sie = d[3];
        end else begin
            m_tf  = m_tf  | tf_hw;
            m_scf = m_scf | scf_hw;
        end
        cyc   = e;
        x.led = m_led;
        x.irq = (m_tf & m_tie) | (m_scf & m_sie);
        x.sel = sel;
        sb.push_back(x);
    endtask

    // Called at a negedge; applies inputs, takes one rising edge, returns at the next negedge.
    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr);
        addr = a; data_in = d; read = rd; write = wr; sw_in = sw_cur;
        @(posedge clk);
        model_edge(a, d, rd, wr, sw_cur);
        @(negedge clk);
    endtask

    task automatic idle();
        step(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr_reg(input logic [1:0] off, input logic [7:0] d);
        step(BASE | 16'(off), d, 1'b0, 1'b1);
    endtask

    task automatic rd_reg(input logic [1:0] off);
        step(BASE | 16'(off), 8'h00, 1'b1, 1'b0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check("data_out", data_out, x.dout);
                check("led_out", led_out, x.led);
                check("irq", irq, x.irq);
                check("io_sel", io_sel, x.sel);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          n;
        logic [1:0]  off;
        logic [15:0] a;
        logic [7:0]  d;
        logic        rd, wr;

        rst = 1'b0; addr = 16'h0; data_in = 8'h0; read = 1'b0; write = 1'b0;
        sw_cur = 8'h00; sw_in = 8'h00;
        model_reset();
        #12;
        check("reset_led", led_out, 8'h00);
        check("reset_irq", irq, 1'b0);
        check("reset_dout", data_out, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // LED write and read-back
        wr_reg(2'd0, 8'hA5);
        rd_reg(2'd0);
        check("led_a5", led_out, 8'hA5);
        check("dout_a5", data_out, 8'hA5);

        // Out-of-window and in-window decode
        addr = 16'h00F0; read = 1'b1; write = 1'b0;
        #1 check("io_sel_outside", io_sel, 1'b0);
        step(16'h00F0, 8'h00, 1'b1, 1'b0);
        check("dout_outside", data_out, 8'h00);
        addr = 16'hFFF2; read = 1'b1;
        #1 check("io_sel_inside", io_sel, 1'b1);
        step(16'hFFF1, 8'h5A, 1'b1, 1'b1);
        check("dout_rd_wr", data_out, 8'h00);

        // Timer latency with PRESCALE=4, reload 3: 12 edges
        wr_reg(2'd3, 8'h02);
        wr_reg(2'd2, 8'h03);
        n = 0;
        while (!irq && n < 40) begin idle(); n++; end
        check("tf_latency", n, 12);
        rd_reg(2'd2);
        check("timer_reloaded", data_out, 8'h03);

        // W1C on the exact expiry edge loses to the hardware set
        n = 0;
        while (!m_expire(cyc + 1) && n < 40) begin idle(); n++; end
        check("expiry_found", n < 40, 1'b1);
        wr_reg(2'd3, 8'h03);
        check("tf_race_irq", irq, 1'b1);
        rd_reg(2'd3);
        check("tf_race_status", data_out, 8'h03);
        wr_reg(2'd3, 8'h03);
        check("tf_cleared_irq", irq, 1'b0);

        // Switch change through the synchronizer
        wr_reg(2'd3, 8'h0C);
        check("scf_clear_irq", irq, 1'b0);
        sw_cur = 8'h01;
        rd_reg(2'd1);
        rd_reg(2'd1);
        rd_reg(2'd1);
        check("sw_by_3rd_edge", data_out, 8'h01);
        check("scf_irq", irq, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) sw_cur = 8'($urandom);
            off = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 9) < 8) ? (BASE | 16'(off)) : 16'($urandom);
            rd  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 3) == 0);
            d   = (a[1:0] == 2'd2) ? 8'($urandom_range(0, 6)) : 8'($urandom);
            step(a, d, rd, wr);
        end

        // Reset in the middle of a count
        sw_cur = 8'h00;
        wr_reg(2'd0, 8'h3C);
        wr_reg(2'd3, 8'h07);
        wr_reg(2'd2, 8'h05);
        n = 0;
        while (!irq && n < 40) begin idle(); n++; end
        check("pre_reset_irq", irq, 1'b1);
        idle();
        idle();
        rd_reg(2'd0);
        check("pre_reset_dout", data_out, 8'h3C);
        read = 1'b0; write = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("async_rst_led", led_out, 8'h00);
        check("async_rst_irq", irq, 1'b0);
        check("async_rst_dout", data_out, 8'h00);
        check("async_rst_sel", io_sel, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 50; i++) begin
            rd_reg(2'd2);
            check("count_after_reset", data_out, 8'h00);
        end

        n = 0;
        while (sb.size() > 0 && n < 10) begin @(negedge clk); n++; end
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'hFFF0, giving the base of a 4-byte I/O window; bits [1:0] of this value are zero.
REQ-002 The block SHALL have parameter PRESCALE, default 4, giving the clk cycles per timer tick (legal range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port addr, input, 16 bits: CPU memory address.
REQ-006 The block SHALL have port data_in, input, 8 bits: CPU write data.
REQ-007 The block SHALL have port read, input, 1 bit: CPU read strobe, level.
REQ-008 The block SHALL have port write, input, 1 bit: CPU write strobe, level.
REQ-009 The block SHALL have port data_out, output, 8 bits: read data to the CPU.
REQ-010 The block SHALL have port io_sel, output, 1 bit: high when the window is addressed, so the top level can mux data_out over the RAM data.
REQ-011 The block SHALL have port sw_in, input, 8 bits: asynchronous board switches.
REQ-012 The block SHALL have port led_out, output, 8 bits: LED register contents.
REQ-013 The block SHALL have port irq, output, 1 bit: equals STATUS[0] AND STATUS[1] OR STATUS[2] AND STATUS[3].

Function
REQ-014 io_sel SHALL be combinational: (addr[15:2]==BASE_ADDR[15:2]) AND (read OR write).
REQ-015 The register map SHALL be offset 0 LED (R/W), 1 SW (R), 2 TIMER (read = current count, write = reload value), 3 STATUS (R/W1C).
REQ-016 STATUS SHALL hold bit0 TF (timer expired), bit1 TIE (R/W), bit2 SCF (switch changed), bit3 SIE (R/W), and bits 7:4 reading as 0.
REQ-017 The read path SHALL register data_out one cycle after a clk edge where read and io_sel are both high, and SHALL drive data_out to 8'h00 one cycle after any non-selected or non-read cycle.
REQ-018 Writes SHALL be level-sensitive: every clk edge with write and io_sel both high updates the addressed register; a held write repeats idempotently.
REQ-019 When read and write are asserted together, the write SHALL take effect and data_out SHALL be 8'h00.
REQ-020 sw_in SHALL pass through a two-flop synchronizer; the SW register is the second flop; SCF SHALL be set on any cycle where the synchronized value differs from the previous one.
REQ-021 The timer SHALL be an 8-bit down counter with reload register RL and a prescale counter; when RL==0 the timer SHALL be stopped and the count SHALL hold at 0.
REQ-022 On each prescale tick the count SHALL decrement; on a tick with count==1, the count SHALL load RL and TF SHALL set on the same edge.
REQ-023 A write to TIMER SHALL load both RL and the count with data_in and SHALL clear the prescale counter.
REQ-024 A write to STATUS SHALL clear TF and/or SCF where data_in bit is 1, and SHALL load TIE and SIE from data_in[1] and data_in[3].
REQ-025 A hardware set of TF or SCF in the same cycle as a W1C of that bit SHALL win, leaving the bit at 1.
REQ-026 Writes to SW and to unmapped bits SHALL be ignored.

Reset
REQ-027 With rst low, LED, RL, count, prescale counter, STATUS, synchronizer flops, and data_out SHALL all be 0 immediately, independent of clk, so led_out=0 and irq=0.
REQ-028 Reset asserted mid-count SHALL abandon the count; after release, the timer SHALL remain stopped until TIMER is written.

Structure
REQ-029 Register offsets, STATUS bit positions, and the default BASE_ADDR SHALL live in the shared CPU package, shared with the memory and top-level decode.
REQ-030 The timer (prescaler, down counter, reload, tick flag) SHALL be one sub-module io_timer; everything else SHALL be inline.

Verification
REQ-031 The bench SHALL check: write 8'hA5 to 16'hFFF0, then read 16'hFFF0 -> led_out=8'hA5, and data_out=8'hA5 one cycle after read.
REQ-032 The bench SHALL check: read 16'h00F0 -> io_sel=0 and data_out=8'h00.
REQ-033 The bench SHALL check: with PRESCALE=4, write 8'h03 to TIMER -> TF sets exactly 12 clk after the write edge, and the count reloads to 3.
REQ-034 The bench SHALL check: with TIE=1 and TF set, write 8'h03 to STATUS on the exact expiry cycle -> TF stays 1 and irq stays 1.
REQ-035 The bench SHALL check: sw_in toggles 8'h00->8'h01 -> SW reads 8'h01 by the 3rd edge, SCF=1, and with SIE=1, irq=1.
REQ-036 The bench SHALL check: assert rst mid-count -> all outputs 0 asynchronously, and after release the count stays 0 for 50 cycles.
